// File: rtl/sync_filter.sv
// Per-bit multi-flop synchroniser followed by a saturating-count glitch filter.
// Define SYNC_FILTER_EDGE_DETECT_EN to build the registered rise/fall pulse outputs.
module sync_filter #(
    parameter int unsigned             DATA_WIDTH    = 1,
    parameter int unsigned             SYNC_STAGES   = 2,
    parameter int unsigned             FILTER_CYCLES = 4,
    parameter logic [DATA_WIDTH-1:0]   RESET_VALUE   = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in,
    output logic [DATA_WIDTH-1:0] out,
    output logic [DATA_WIDTH-1:0] rise,
    output logic [DATA_WIDTH-1:0] fall
);

    localparam int unsigned    COUNT_WIDTH = $clog2(FILTER_CYCLES + 1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = COUNT_WIDTH'(FILTER_CYCLES - 1);

    // chain[0] samples in; chain[SYNC_STAGES-1] is the synchronised level
    (* ASYNC_REG = "TRUE" *)
    logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0]  chain = {SYNC_STAGES{RESET_VALUE}};
    logic [DATA_WIDTH-1:0]                   out_q = RESET_VALUE;
    logic [DATA_WIDTH-1:0][COUNT_WIDTH-1:0]  count = '0;

    logic [DATA_WIDTH-1:0]                   sync_bits;
    logic [DATA_WIDTH-1:0]                   out_next;
    logic [DATA_WIDTH-1:0][COUNT_WIDTH-1:0]  count_next;

    assign sync_bits = chain[SYNC_STAGES-1];
    assign out       = out_q;

    // Disagreement must persist FILTER_CYCLES edges; the last one loads out and clears the count
    always_comb begin
        out_next   = out_q;
        count_next = '0;
        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            if (sync_bits[i] != out_q[i]) begin
                if (count[i] == COUNT_MAX)
                    out_next[i] = sync_bits[i];
                else
                    count_next[i] = count[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            chain <= {SYNC_STAGES{RESET_VALUE}};
            out_q <= RESET_VALUE;
            count <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], in};
            out_q <= out_next;
            count <= count_next;
        end
    end

`ifdef SYNC_FILTER_EDGE_DETECT_EN
    logic [DATA_WIDTH-1:0] rise_q = '0;
    logic [DATA_WIDTH-1:0] fall_q = '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            rise_q <= out_next & ~out_q;
            fall_q <= ~out_next & out_q;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;
`else
    assign rise = '0;
    assign fall = '0;
`endif

endmodule

// File: tb/tb_sync_filter.sv
// Directed self-checking bench for sync_filter (DATA_WIDTH=4, SYNC_STAGES=2, FILTER_CYCLES=4).
// Pulse expectations follow SYNC_FILTER_EDGE_DETECT_EN; out expectations are build-independent.
module tb_sync_filter;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] in;
    logic [3:0] out;
    logic [3:0] rise;
    logic [3:0] fall;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

`ifdef SYNC_FILTER_EDGE_DETECT_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    sync_filter #(
        .DATA_WIDTH    (4),
        .SYNC_STAGES   (2),
        .FILTER_CYCLES (4),
        .RESET_VALUE   (4'b0000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .in    (in),
        .out   (out),
        .rise  (rise),
        .fall  (fall)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] pulse(input logic [3:0] v);
        return EDGE_EN ? v : 4'b0000;
    endfunction

    // Advance one rising edge and settle 1 time unit after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] o, input logic [3:0] r,
                           input logic [3:0] f);
        chk({tag, ".out"},  out,  o);
        chk({tag, ".rise"}, rise, r);
        chk({tag, ".fall"}, fall, f);
    endtask

    // n edges during which out must hold o with no pulses
    task automatic hold(input string tag, input int unsigned n, input logic [3:0] o);
        for (int unsigned k = 0; k < n; k++) begin
            tick();
            chk_all(tag, o, 4'b0000, 4'b0000);
        end
    endtask

    initial begin
        reset = 1'b1;
        in    = 4'b1111;

        // Reset held two edges with in all ones
        tick();
        chk_all("rst_e0", 4'b0000, 4'b0000, 4'b0000);
        tick();
        chk_all("rst_e1", 4'b0000, 4'b0000, 4'b0000);
        reset = 1'b0;
        hold("rst_rel", 5, 4'b0000);
        tick();
        chk_all("rst_out5", 4'b1111, pulse(4'b1111), 4'b0000);
        tick();
        chk_all("rst_out6", 4'b1111, 4'b0000, 4'b0000);

        // Reset back to zero with in matching RESET_VALUE: no pulses afterwards
        reset = 1'b1;
        in    = 4'b0000;
        tick();
        chk_all("rst2", 4'b0000, 4'b0000, 4'b0000);
        reset = 1'b0;
        hold("quiet", 6, 4'b0000);

        // Three-cycle glitch on bit 1 is rejected
        in = 4'b0010;
        tick();
        chk_all("glitch_c0", 4'b0000, 4'b0000, 4'b0000);
        tick();
        tick();
        in = 4'b0000;
        hold("glitch", 8, 4'b0000);

        // Latency: out changes after edge 5, not earlier
        in = 4'b0001;
        hold("lat", 5, 4'b0000);
        tick();
        chk_all("lat_e5", 4'b0001, pulse(4'b0001), 4'b0000);
        tick();
        chk_all("lat_e6", 4'b0001, 4'b0000, 4'b0000);

        // Simultaneous opposite transitions on bits 0 and 1
        in = 4'b0010;
        hold("simul", 5, 4'b0001);
        tick();
        chk_all("simul_e5", 4'b0010, pulse(4'b0010), pulse(4'b0001));
        tick();
        chk_all("simul_e6", 4'b0010, 4'b0000, 4'b0000);

        // Clear to zero, then reset on the edge that would have loaded bit 3
        reset = 1'b1;
        in    = 4'b0000;
        tick();
        reset = 1'b0;
        hold("pre_mid", 3, 4'b0000);
        in = 4'b1000;
        hold("mid_cnt", 5, 4'b0000);
        reset = 1'b1;
        tick();
        chk_all("mid_rst", 4'b0000, 4'b0000, 4'b0000);
        reset = 1'b0;
        hold("mid_rel", 5, 4'b0000);
        tick();
        chk_all("mid_e5", 4'b1000, pulse(4'b1000), 4'b0000);
        tick();
        chk_all("mid_e6", 4'b1000, 4'b0000, 4'b0000);

        // Falling transition on bit 3
        in = 4'b0000;
        hold("fall", 5, 4'b1000);
        tick();
        chk_all("fall_e5", 4'b0000, 4'b0000, pulse(4'b1000));
        tick();
        chk_all("fall_e6", 4'b0000, 4'b0000, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
